// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pipeline: engine mode encodings,
// scheduler FSM states and the fixed row/column port widths.
package conv_pkg;

  localparam int PIX_W      = 8;
  localparam int COL_PORT_W = 10;
  localparam int ROW_PORT_W = 9;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_SOBEL = 2'b01,
    MODE_GAUSS = 2'b10,
    MODE_RSVD  = 2'b11
  } conv_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_t;

  // The reserved encoding never reaches the engine.
  function automatic logic mode_is_valid(input logic [1:0] m);
    return m != MODE_RSVD;
  endfunction

endpackage

// File: rtl/conv_frame_scheduler_if.sv
// Pixel source handshake and engine-side pixel stream of the frame scheduler.
interface conv_frame_scheduler_if;
  import conv_pkg::*;

  // Source: a pixel transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on scheduler state, never on s_valid.
  // Engine: eng_valid marks a pixel for one cycle, there is no backpressure.
  logic [PIX_W-1:0]      s_pixel;
  logic                  s_valid;
  logic                  s_ready;
  logic [PIX_W-1:0]      eng_pixel;
  logic                  eng_valid;
  logic [1:0]            eng_mode;
  logic [COL_PORT_W-1:0] col;
  logic [ROW_PORT_W-1:0] row;

  modport master (
    input  s_pixel, s_valid,
    output s_ready, eng_pixel, eng_valid, eng_mode, col, row
  );

  modport slave (
    output s_pixel, s_valid,
    input  s_ready, eng_pixel, eng_valid, eng_mode, col, row
  );

endinterface

// File: rtl/conv_pixel_counter.sv
// Column/row position of the next pixel to accept; wraps at the frame edges.
module conv_pixel_counter #(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign last = (col == LAST_COL) && (row == LAST_ROW);

endmodule

// File: rtl/conv_frame_scheduler.sv
// Feeds one frame of source pixels to the convolution engine, then a run of
// zero pixels to drain its line buffers, and pulses frame_done.
module conv_frame_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FLUSH_LEN  = IMG_WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode_req,
  input  logic                    mode_req_valid,
  output logic                    busy,
  output logic                    frame_done,
  output sched_state_t            dbg_state,
  conv_frame_scheduler_if.master  bus
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FL_W  = $clog2(FLUSH_LEN + 1);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_LEN - 1);

  sched_state_t     state, state_next;
  logic [1:0]       pending_mode;
  logic [FL_W-1:0]  flush_cnt;
  logic [COL_W-1:0] cnt_col;
  logic [ROW_W-1:0] cnt_row;
  logic             cnt_last;
  logic             accept;
  logic             start_frame;
  logic             mode_ok;

  assign mode_ok     = mode_req_valid && mode_is_valid(mode_req);
  assign start_frame = (state == ST_IDLE) && start;
  assign accept      = (state == ST_STREAM) && bus.s_valid;
  assign dbg_state   = state;

  conv_pixel_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_frame),
    .advance (accept),
    .col     (cnt_col),
    .row     (cnt_row),
    .last    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    bus.s_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        busy        = 1'b1;
        bus.s_ready = 1'b1;
        if (accept && cnt_last) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (flush_cnt == FLUSH_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A mode request arriving with start wins over the pending register so
  // that it applies to the frame being started.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.eng_pixel <= '0;
      bus.eng_valid <= 1'b0;
      bus.eng_mode  <= MODE_PASS;
      bus.col       <= '0;
      bus.row       <= '0;
      pending_mode  <= MODE_PASS;
      flush_cnt     <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= (state == ST_DONE);
      if (mode_ok) pending_mode <= mode_req;
      case (state)
        ST_IDLE: begin
          bus.eng_valid <= 1'b0;
          flush_cnt     <= '0;
          if (start) begin
            bus.eng_mode <= mode_ok ? mode_req : pending_mode;
            bus.col      <= '0;
            bus.row      <= '0;
          end
        end
        ST_STREAM: begin
          bus.eng_valid <= accept;
          flush_cnt     <= '0;
          if (accept) begin
            bus.eng_pixel <= bus.s_pixel;
            bus.col       <= COL_PORT_W'(cnt_col);
            bus.row       <= ROW_PORT_W'(cnt_row);
          end
        end
        ST_FLUSH: begin
          bus.eng_pixel <= '0;
          bus.eng_valid <= 1'b1;
          flush_cnt     <= flush_cnt + FL_W'(1);
        end
        default: begin
          bus.eng_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed bench for conv_frame_scheduler with an 8x4 frame and 10-pixel flush.
module tb_conv_frame_scheduler;
  import conv_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int FL = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode_req;
  logic         mode_req_valid;
  logic         busy;
  logic         frame_done;
  sched_state_t dbg_state;

  conv_frame_scheduler_if bus ();

  conv_frame_scheduler #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FLUSH_LEN  (FL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .busy           (busy),
    .frame_done     (frame_done),
    .dbg_state      (dbg_state),
    .bus            (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int frames_expected = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic [1:0] mode_req;
    logic       mode_req_valid;
    logic       s_valid;
    logic [7:0] s_pixel;
    logic       e_valid;
    logic [7:0] e_pixel;
    logic [1:0] e_mode;
    logic       e_busy;
    logic       e_ready;
    logic       e_fd;
    logic [9:0] e_col;
    logic [8:0] e_row;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, int'(bus.eng_valid), 0);
    chk({tag, "_pixel"}, int'(bus.eng_pixel), 0);
    chk({tag, "_mode"},  int'(bus.eng_mode), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_fd"},    int'(frame_done), 0);
    chk({tag, "_ready"}, int'(bus.s_ready), 0);
    chk({tag, "_col"},   int'(bus.col), 0);
    chk({tag, "_row"},   int'(bus.row), 0);
    chk({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  // One full frame: start, 32 pixels (optionally with a gap before each),
  // flush run, frame_done; optional stray starts and a mid-frame mode request.
  task automatic run_frame(input logic use_mode, input logic [1:0] start_mode,
                           input logic [1:0] exp_mode, input bit gaps,
                           input bit stray, input bit mid_en,
                           input logic [1:0] mid_mode, input logic [7:0] base);
    logic [7:0] e;
    start = 1'b1; mode_req_valid = use_mode; mode_req = start_mode;
    tick();
    start = 1'b0; mode_req_valid = 1'b0;
    chk("frm_start_busy", int'(busy), 1);
    chk("frm_start_mode", int'(bus.eng_mode), int'(exp_mode));
    chk("frm_start_state", int'(dbg_state), int'(ST_STREAM));
    for (int i = 0; i < W * H; i++) begin
      if (gaps) begin
        bus.s_valid = 1'b0;
        tick();
        chk("frm_bubble_valid", int'(bus.eng_valid), 0);
      end
      chk("frm_s_ready", int'(bus.s_ready), 1);
      bus.s_valid = 1'b1;
      bus.s_pixel = base + 8'(i);
      exp_q.push_back(base + 8'(i));
      if (stray && i == 5) start = 1'b1;
      if (mid_en && i == 10) begin
        mode_req_valid = 1'b1; mode_req = mid_mode;
      end
      tick();
      start = 1'b0; mode_req_valid = 1'b0; bus.s_valid = 1'b0;
      chk("frm_pix_valid", int'(bus.eng_valid), 1);
      if (exp_q.size() == 0) begin
        chk("frm_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("frm_pixel", int'(bus.eng_pixel), int'(e));
      end
      chk("frm_col", int'(bus.col), i % W);
      chk("frm_row", int'(bus.row), i / W);
      chk("frm_mode", int'(bus.eng_mode), int'(exp_mode));
    end
    chk("frm_ready_after_last", int'(bus.s_ready), 0);
    chk("frm_busy_after_last", int'(busy), 1);
    for (int f = 0; f < FL; f++) begin
      tick();
      chk("flush_valid", int'(bus.eng_valid), 1);
      chk("flush_pixel", int'(bus.eng_pixel), 0);
      chk("flush_fd", int'(frame_done), 0);
      chk("flush_busy", int'(busy), (f < FL - 1) ? 1 : 0);
      chk("flush_mode", int'(bus.eng_mode), int'(exp_mode));
    end
    if (stray) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_fd", int'(frame_done), 1);
    chk("done_valid", int'(bus.eng_valid), 0);
    chk("done_busy", int'(busy), 0);
    tick();
    chk("post_fd", int'(frame_done), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_state", int'(dbg_state), int'(ST_IDLE));
    frames_expected++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode_req = 2'b00; mode_req_valid = 1'b0;
    bus.s_valid = 1'b0; bus.s_pixel = 8'h00;

    //          rst st md  mv sv pix    ev pix    em  bz rdy fd col row
    vecs[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0};
    vecs[1] = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0};
    vecs[4] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 2'd1, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0};
    vecs[5] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0};
    vecs[6] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b1, 1'b0, 10'd1, 9'd0};
    vecs[7] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0};
    vecs[8] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0};
    vecs[9] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0};

    for (int v = 0; v < 10; v++) begin
      rst_n = vecs[v].rst_n; start = vecs[v].start;
      mode_req = vecs[v].mode_req; mode_req_valid = vecs[v].mode_req_valid;
      bus.s_valid = vecs[v].s_valid; bus.s_pixel = vecs[v].s_pixel;
      tick();
      chk($sformatf("vec%0d_valid", v), int'(bus.eng_valid), int'(vecs[v].e_valid));
      chk($sformatf("vec%0d_mode", v), int'(bus.eng_mode), int'(vecs[v].e_mode));
      chk($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].e_busy));
      chk($sformatf("vec%0d_ready", v), int'(bus.s_ready), int'(vecs[v].e_ready));
      chk($sformatf("vec%0d_fd", v), int'(frame_done), int'(vecs[v].e_fd));
      if (vecs[v].e_valid) begin
        chk($sformatf("vec%0d_pixel", v), int'(bus.eng_pixel), int'(vecs[v].e_pixel));
        chk($sformatf("vec%0d_col", v), int'(bus.col), int'(vecs[v].e_col));
        chk($sformatf("vec%0d_row", v), int'(bus.row), int'(vecs[v].e_row));
      end
    end
    chk_reset_values("tbl_end");

    rst_n = 1'b1; start = 1'b0; mode_req_valid = 1'b0; bus.s_valid = 1'b0;

    // contiguous frame, mode 01 given with start
    run_frame(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
    // source gaps, stray starts, mode 10 requested mid-frame
    run_frame(1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 2'b10, 8'd100);
    // pending mode 10 takes effect on the next start
    run_frame(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'd200);
    // reserved mode with start keeps 10
    run_frame(1'b1, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 8'd50);

    // reset at pixel 17 aborts the frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.s_valid = 1'b1; bus.s_pixel = 8'(i);
      tick();
      chk("abort_pixel", int'(bus.eng_pixel), i);
    end
    bus.s_pixel = 8'd17; rst_n = 1'b0;
    tick();
    bus.s_valid = 1'b0;
    chk_reset_values("abort_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_fd", int'(frame_done), 0);
      chk("abort_idle_busy", int'(busy), 0);
    end

    // clean frame after reset uses the reset mode 00
    run_frame(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd7);

    repeat (2) tick();
    chk("frame_done_count", fd_count, frames_expected);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
